// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin front end for a single APB master port; one transfer at a time, all outputs registered.
// Optional ACCESS wait-timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_write,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_done,
  output logic              o_m0_err,
  input  logic              i_m1_req,
  input  logic              i_m1_write,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_done,
  output logic              o_m1_err,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pwrite,
  output logic              o_psel,
  output logic              o_penable,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q;
  logic                grant_q, last_grant_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q, psel_q, penable_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
  logic                m0_done_q, m1_done_q, m0_err_q, m1_err_q;

  logic                win_d, finish_d, err_d, timeout_d;
  logic [DATA_W-1:0]   rdata_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_q;
  assign timeout_d = !i_pready && (wait_q == TmoLimit);
`else
  // Without the abort feature the limit has no effect on the logic.
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_d  = 1'b0;
`endif

  // Winner is 1 only when m1 requests and m0 does not hold the tie-break.
  always_comb begin
    win_d    = i_m1_req && !(i_m0_req && last_grant_q);
    finish_d = i_pready || timeout_d;
    rdata_d  = (timeout_d || pwrite_q) ? '0 : i_prdata;
    err_d    = timeout_d ? 1'b1 : i_pslverr;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_m0_req || i_m1_req) begin
            state_q      <= SETUP;
            psel_q       <= 1'b1;
            grant_q      <= win_d;
            last_grant_q <= win_d;
            paddr_q      <= win_d ? i_m1_addr  : i_m0_addr;
            pwrite_q     <= win_d ? i_m1_write : i_m0_write;
            pwdata_q     <= win_d ? i_m1_wdata : i_m0_wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ACCESS: begin
          if (finish_d) begin
            state_q    <= RESP;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            m0_done_q  <= !grant_q;
            m1_done_q  <= grant_q;
            m0_rdata_q <= grant_q ? '0 : rdata_d;
            m1_rdata_q <= grant_q ? rdata_d : '0;
            m0_err_q   <= !grant_q && err_d;
            m1_err_q   <= grant_q && err_d;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            wait_q <= wait_q + 16'd1;
          end
`endif
        end
        RESP: begin
          state_q    <= IDLE;
          m0_done_q  <= 1'b0;
          m1_done_q  <= 1'b0;
          m0_rdata_q <= '0;
          m1_rdata_q <= '0;
          m0_err_q   <= 1'b0;
          m1_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_paddr    = paddr_q;
  assign o_pwrite   = pwrite_q;
  assign o_pwdata   = pwdata_q;
  assign o_psel     = psel_q;
  assign o_penable  = penable_q;
  assign o_m0_rdata = m0_rdata_q;
  assign o_m1_rdata = m1_rdata_q;
  assign o_m0_done  = m0_done_q;
  assign o_m1_done  = m1_done_q;
  assign o_m0_err   = m0_err_q;
  assign o_m1_err   = m1_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random rounds against a transaction-level round-robin model.
module tb_apb_master_arbiter;

  localparam int unsigned TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_m0_req = 1'b0, i_m0_write = 1'b0;
  logic [31:0] i_m0_addr = '0, i_m0_wdata = '0;
  logic [31:0] o_m0_rdata;
  logic        o_m0_done, o_m0_err;
  logic        i_m1_req = 1'b0, i_m1_write = 1'b0;
  logic [31:0] i_m1_addr = '0, i_m1_wdata = '0;
  logic [31:0] o_m1_rdata;
  logic        o_m1_done, o_m1_err;
  logic [31:0] o_paddr, o_pwdata;
  logic        o_pwrite, o_psel, o_penable;
  logic [31:0] i_prdata = '0;
  logic        i_pready = 1'b0, i_pslverr = 1'b0;

  always #5 i_clk = ~i_clk;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_write(i_m0_write), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_rdata(o_m0_rdata), .o_m0_done(o_m0_done), .o_m0_err(o_m0_err),
    .i_m1_req(i_m1_req), .i_m1_write(i_m1_write), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .o_m1_rdata(o_m1_rdata), .o_m1_done(o_m1_done), .o_m1_err(o_m1_err),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwdata(o_pwdata), .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  int unsigned n_checks = 0, n_errors = 0;

  // Model state: pending request per requester and the last granted index.
  logic        p_req[2];
  logic        p_wr[2];
  logic [31:0] p_addr[2], p_wd[2];
  int          last_g;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_pins();
    i_m0_req = p_req[0]; i_m0_write = p_wr[0]; i_m0_addr = p_addr[0]; i_m0_wdata = p_wd[0];
    i_m1_req = p_req[1]; i_m1_write = p_wr[1]; i_m1_addr = p_addr[1]; i_m1_wdata = p_wd[1];
  endtask

  task automatic post(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p_req[m] = 1'b1; p_wr[m] = wr; p_addr[m] = a; p_wd[m] = d;
    drive_pins();
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One complete transfer starting in IDLE with the current pending requests.
  task automatic do_xfer(input int unsigned wait_cyc, input logic [31:0] rdat, input logic serr);
    int          w;
    logic        aborted;
    logic [31:0] ea, ewd, erd;
    logic        ewr, eerr;
    w = (p_req[0] && p_req[1]) ? (1 - last_g) : (p_req[1] ? 1 : 0);
    last_g = w;
    ea = p_addr[w]; ewd = p_wd[w]; ewr = p_wr[w];

    tick();
    check("setup_bus", {o_psel, o_penable}, 2'b10);
    check("setup_addr", o_paddr, ea);
    check("setup_ctl", {o_pwrite, o_pwdata}, {ewr, ewd});
    check("setup_done", {o_m1_done, o_m0_done}, 2'b00);
    tick();
    check("access_bus", {o_psel, o_penable}, 2'b11);

    aborted = 1'b0;
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      i_pready = 1'b0;
      i_prdata = $urandom;
      tick();
`ifdef APB_ARB_TIMEOUT_EN
      if (i == TMO) begin
        aborted = 1'b1;
        break;
      end
`endif
      check("wait_bus", {o_psel, o_penable}, 2'b11);
      check("wait_hold", {o_paddr, o_pwdata}, {ea, ewd});
      check("wait_done", {o_m1_done, o_m0_done}, 2'b00);
    end
    if (!aborted) begin
      i_pready = 1'b1; i_prdata = rdat; i_pslverr = serr;
      tick();
    end
    i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = $urandom;

    erd  = (aborted || ewr) ? 32'h0 : rdat;
    eerr = aborted ? 1'b1 : serr;
    check("resp_bus", {o_psel, o_penable}, 2'b00);
    check("resp_done", {o_m1_done, o_m0_done}, (w == 1) ? 2'b10 : 2'b01);
    if (w == 1) begin
      check("resp_m1", {o_m1_rdata, o_m1_err}, {erd, eerr});
      check("resp_m0_quiet", {o_m0_rdata, o_m0_err}, 33'h0);
    end else begin
      check("resp_m0", {o_m0_rdata, o_m0_err}, {erd, eerr});
      check("resp_m1_quiet", {o_m1_rdata, o_m1_err}, 33'h0);
    end
    p_req[w] = 1'b0;
    drive_pins();

    tick();
    check("idle_out", {o_psel, o_penable, o_m1_done, o_m0_done, o_m1_err, o_m0_err}, 6'h0);
    check("idle_rdata", {o_m1_rdata, o_m0_rdata}, 64'h0);
    check("idle_hold", o_paddr, ea);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 1'b0; p_wr[m] = 1'b0; p_addr[m] = '0; p_wd[m] = '0;
    end
    last_g = 1;
    #12;
    check("reset_ctl", {o_psel, o_penable, o_pwrite, o_m1_done, o_m0_done, o_m1_err, o_m0_err}, 7'h0);
    check("reset_data", {o_paddr, o_pwdata, o_m0_rdata, o_m1_rdata}, 128'h0);
    @(posedge i_clk); #3; i_rst = 1'b1;

    // Both from reset, then held continuously: m0, m1, m0, m1.
    post(0, 1'b1, 32'h10, 32'h11);
    post(1, 1'b1, 32'h20, 32'h22);
    for (int k = 0; k < 4; k++) begin
      int nxt;
      nxt = (p_req[0] && p_req[1]) ? (1 - last_g) : 0;
      do_xfer(0, $urandom, 1'b0);
      post(nxt, 1'b1, (nxt == 1) ? 32'h20 : 32'h10, (nxt == 1) ? 32'h22 : 32'h11);
    end
    while (p_req[0] || p_req[1]) do_xfer(0, $urandom, 1'b0);

    post(0, 1'b0, 32'h1000_0004, 32'h0);
    do_xfer(0, 32'hDEAD_BEEF, 1'b0);
    post(1, 1'b1, 32'h4000_0100, 32'hCAFE_F00D);
    do_xfer(3, 32'h1234_5678, 1'b0);
    post(0, 1'b0, 32'h0000_0040, 32'h0);
    do_xfer(0, 32'h5555_AAAA, 1'b1);
    post(1, 1'b0, 32'h0000_0080, 32'h0);
    do_xfer(TMO, 32'h0BAD_CAFE, 1'b0);
    post(0, 1'b0, 32'h0000_00C0, 32'h0);
    do_xfer(100, 32'h7777_7777, 1'b0);

    // Asynchronous reset in the middle of ACCESS.
    post(0, 1'b1, 32'h0000_0200, 32'hAAAA_0000);
    tick(); tick();
    check("pre_rst_access", {o_psel, o_penable}, 2'b11);
    #2; i_rst = 1'b0;
    #1;
    check("rst_async", {o_psel, o_penable, o_m1_done, o_m0_done}, 4'h0);
    p_req[0] = 1'b0; p_req[1] = 1'b0; drive_pins();
    last_g = 1;
    @(posedge i_clk); #3; i_rst = 1'b1;
    post(1, 1'b0, 32'h0000_0300, 32'h0);
    do_xfer(1, 32'h3333_3333, 1'b0);
    post(0, 1'b1, 32'h0000_0400, 32'h4444_4444);
    post(1, 1'b1, 32'h0000_0500, 32'h5555_5555);
    do_xfer(0, $urandom, 1'b0);
    do_xfer(0, $urandom, 1'b0);

    for (int r = 0; r < 40; r++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m] && ($urandom_range(0, 1) == 1))
          post(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!p_req[0] && !p_req[1])
        post(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      do_xfer($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
